nonce_sequencer: RTL and testbench
==================================

NONCE_SEQUENCER -- requirements
Module: nonce_sequencer

Interface
REQ-001 SHALL have parameter NONCE_STRIDE, default 1, nonce increment per attempt (1..2^16), used to partition nonce space across cores.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port load_valid  input  1  header byte strobe.
REQ-005 SHALL have port load_data  input  8  header byte, wire order.
REQ-006 SHALL have port load_ready  output  1  high when bytes are accepted (state IDLE).
REQ-007 SHALL have port zbits  input  8  difficulty: required count of zero LSBs of hash.
REQ-008 SHALL have port run  input  1  start-mining pulse.
REQ-009 SHALL have port abort  input  1  stop request.
REQ-010 SHALL have port sha_start  output  1  one-cycle start pulse to sha256.
REQ-011 SHALL have port sha_block  output  640  header presented to sha256.
REQ-012 SHALL have port sha_hash  input  256  digest from sha256.
REQ-013 SHALL have port sha_done  input  1  sha256 completion level.
REQ-014 SHALL have ports busy, found, exhausted  output  1 each  status flags; found_nonce  output  32  winning nonce.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
REQ-016 In IDLE, each load_valid byte k (k = 0..79, mod-80 counter) SHALL be written to sha_block[639-8k -: 8]; counter reaching 80 sets loaded and wraps to 0.
REQ-017 Nonce value N SHALL be {byte79,byte78,byte77,byte76}; sha_block[31:0] = {N[7:0],N[15:8],N[23:16],N[31:24]}.
REQ-018 run in IDLE with loaded=1 SHALL go to ISSUE next cycle; run with loaded=0, or run outside IDLE/FOUND/EXHAUSTED, SHALL be ignored.
REQ-019 run in FOUND or EXHAUSTED SHALL clear found/exhausted, advance N by NONCE_STRIDE (FOUND only), and go to ISSUE; run in EXHAUSTED with no stride room SHALL be ignored.
REQ-020 ISSUE SHALL assert sha_start for exactly one cycle, then enter WAIT.
REQ-021 WAIT SHALL exit to CHECK only on a sha_done rising edge (registered previous value 0, current 1); a level held from a prior hash SHALL NOT complete WAIT.
REQ-022 CHECK SHALL declare a hit when sha_hash[zbits-1:0] is all zero (zbits=0 always hits; zbits>=256 never hits).
REQ-023 On hit: found=1, found_nonce=N, state FOUND, held until run, abort or reset.
REQ-024 On miss with N+NONCE_STRIDE <= 32'hFFFFFFFF: N += NONCE_STRIDE, go to ISSUE; otherwise exhausted=1, state EXHAUSTED.
REQ-025 busy SHALL be 1 exactly in ISSUE, WAIT, CHECK.
REQ-026 Per-attempt overhead SHALL be 3 cycles beyond the sha256 latency (ISSUE, edge detect, CHECK).
REQ-027 abort SHALL return to IDLE next cycle from any state, clear found/exhausted, keep loaded and current N; abort has priority over run and sha_done in the same cycle.
REQ-028 load_valid outside IDLE SHALL be ignored and not advance the byte counter.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, sha_block=0, byte counter=0, loaded=0, sha_start=0, busy=0, found=0, exhausted=0, found_nonce=0, edge register=0.
REQ-030 Reset mid-WAIT SHALL discard the attempt; a later sha_done SHALL have no effect until a new load and run.

Configuration
REQ-031 With HASH_COUNTER_EN defined, SHALL add output hash_count (32) counting CHECK entries, cleared by reset and by run from IDLE, wrapping at 2^32.
REQ-032 Without HASH_COUNTER_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Genesis header (nonce bytes 1D AC 2B 7C), zbits=40, run, real sha256 -> found=1, found_nonce=32'h7C2BAC1D after one CHECK; zbits=41 -> no hit on that nonce.
REQ-034 Genesis header with nonce 0x7C2BAC1B, zbits=40, stride 1 -> three sha_start pulses, found_nonce=32'h7C2BAC1D, hash_count=3.
REQ-035 Stub sha256 (fixed nonzero digest LSB=1), nonce 0xFFFFFFFE, zbits=8 -> two attempts, exhausted=1, busy=0.
REQ-036 Stub holds sha_done high continuously -> each attempt still needs a new rising edge; no double CHECK.
REQ-037 abort asserted during WAIT -> IDLE next cycle, sha_start stays 0, N unchanged; rst_n pulse mid-WAIT -> all outputs 0, loaded=0.
REQ-038 zbits=0 -> found on first attempt with found_nonce equal to loaded nonce.

Source files
------------

// File: rtl/nonce_sequencer.sv
// Nonce search sequencer: loads an 80-byte header, issues sha256 attempts and
// steps the nonce until the digest meets the difficulty. Optional HASH_COUNTER_EN adds hash_count.
module nonce_sequencer #(
    parameter int unsigned NONCE_STRIDE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [7:0]   load_data,
    output logic         load_ready,
    input  logic [7:0]   zbits,
    input  logic         run,
    input  logic         abort,
    output logic         sha_start,
    output logic [639:0] sha_block,
    input  logic [255:0] sha_hash,
    input  logic         sha_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce
`ifdef HASH_COUNTER_EN
    ,
    output logic [31:0]  hash_count
`endif
);

    // state     | meaning
    // S_IDLE    | accepting header bytes, waiting for run
    // S_ISSUE   | sha_start pulse for the current nonce
    // S_WAIT    | waiting for a fresh sha_done rising edge
    // S_CHECK   | compare digest LSBs against zbits
    // S_FOUND   | hit held until run/abort
    // S_EXHAUST | nonce space used up
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUST
    } state_t;

    localparam logic [32:0] STRIDE33 = 33'(NONCE_STRIDE);

    state_t         state_q;
    logic [639:0]   blk_q;
    logic [6:0]     byte_cnt_q;
    logic           loaded_q;
    logic           sha_start_q;
    logic           busy_q;
    logic           found_q;
    logic           exhausted_q;
    logic [31:0]    found_nonce_q;
    logic           done_prev_q;

    logic [31:0]    nonce_cur_d;
    logic [32:0]    nonce_sum_d;
    logic           room_d;
    logic [255:0]   hit_mask_d;
    logic           hit_d;
    logic           done_rise_d;
    logic [9:0]     byte_msb_d;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // The nonce lives in the last four header bytes, so it is kept only inside blk_q.
    always_comb begin
        nonce_cur_d = swap32(blk_q[31:0]);
        nonce_sum_d = {1'b0, nonce_cur_d} + STRIDE33;
        room_d      = ~nonce_sum_d[32];
        hit_mask_d  = (256'd1 << zbits) - 256'd1;
        hit_d       = ((sha_hash & hit_mask_d) == '0);
        done_rise_d = sha_done & ~done_prev_q;
        byte_msb_d  = 10'd639 - {byte_cnt_q, 3'b000};
    end

`ifdef HASH_COUNTER_EN
    logic [31:0] hash_count_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            blk_q         <= '0;
            byte_cnt_q    <= '0;
            loaded_q      <= 1'b0;
            sha_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            done_prev_q   <= 1'b0;
`ifdef HASH_COUNTER_EN
            hash_count_q  <= '0;
`endif
        end else begin
            done_prev_q <= sha_done;
            sha_start_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                found_q     <= 1'b0;
                exhausted_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (load_valid) begin
                            blk_q[byte_msb_d -: 8] <= load_data;
                            if (byte_cnt_q == 7'd79) begin
                                byte_cnt_q <= '0;
                                loaded_q   <= 1'b1;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 7'd1;
                            end
                        end
                        if (run && loaded_q) begin
                            state_q     <= S_ISSUE;
                            sha_start_q <= 1'b1;
                            busy_q      <= 1'b1;
`ifdef HASH_COUNTER_EN
                            hash_count_q <= '0;
`endif
                        end
                    end
                    S_ISSUE: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (done_rise_d) begin
                            state_q <= S_CHECK;
`ifdef HASH_COUNTER_EN
                            hash_count_q <= hash_count_q + 32'd1;
`endif
                        end
                    end
                    S_CHECK: begin
                        if (hit_d) begin
                            state_q       <= S_FOUND;
                            found_q       <= 1'b1;
                            found_nonce_q <= nonce_cur_d;
                            busy_q        <= 1'b0;
                        end else if (room_d) begin
                            blk_q[31:0] <= swap32(nonce_sum_d[31:0]);
                            state_q     <= S_ISSUE;
                            sha_start_q <= 1'b1;
                        end else begin
                            state_q     <= S_EXHAUST;
                            exhausted_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                    S_FOUND: begin
                        if (run) begin
                            blk_q[31:0] <= swap32(nonce_sum_d[31:0]);
                            found_q     <= 1'b0;
                            state_q     <= S_ISSUE;
                            sha_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_EXHAUST: begin
                        if (run && room_d) begin
                            exhausted_q <= 1'b0;
                            state_q     <= S_ISSUE;
                            sha_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign load_ready  = (state_q == S_IDLE);
    assign sha_start   = sha_start_q;
    assign sha_block   = blk_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_nonce_q;
`ifdef HASH_COUNTER_EN
    assign hash_count  = hash_count_q;
`endif

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: sha256 stub with programmable latency, directed vector
// table, hand-written corner sequences and a randomized run against a search model.
module tb_nonce_sequencer;

    localparam int unsigned STRIDE = 3;
    localparam logic [31:0] GEN_N  = 32'h7C2BAC1D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [7:0]   load_data = '0;
    logic [7:0]   zbits = '0;
    logic         run = 1'b0;
    logic         abort = 1'b0;
    logic         sha_done = 1'b0;
    logic [255:0] sha_hash = '0;
    logic         load_ready, sha_start, busy, found, exhausted;
    logic [639:0] sha_block;
    logic [31:0]  found_nonce;
`ifdef HASH_COUNTER_EN
    logic [31:0]  hash_count;
`endif

    always #5 clk = ~clk;

    nonce_sequencer #(.NONCE_STRIDE(STRIDE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .zbits      (zbits),
        .run        (run),
        .abort      (abort),
        .sha_start  (sha_start),
        .sha_block  (sha_block),
        .sha_hash   (sha_hash),
        .sha_done   (sha_done),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted),
        .found_nonce(found_nonce)
`ifdef HASH_COUNTER_EN
        ,
        .hash_count (hash_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic [639:0] act, input logic [639:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- sha256 stub ----------------
    int   lat = 4;
    bit   hold_hi = 1'b0;
    bit   fixed_mode = 1'b1;
    bit   stub_kill = 1'b0;
    bit   drop_req = 1'b0;
    bit   drop_ack = 1'b0;
    int   stub_cnt = 0;
    int   starts = 0;
    logic [31:0] stub_n = '0;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Genesis nonce digest has exactly 40 zero LSBs; fixed mode gives LSB=1 otherwise.
    function automatic logic [255:0] hash_fn(input logic [31:0] n);
        logic [31:0] m;
        if (n == GEN_N) return {8'hAB, {207{1'b0}}, 1'b1, 40'h0};
        if (fixed_mode) return 256'h0123_4567_89AB_CDEF_0000_0000_0000_0001;
        m = n * 32'h9E3779B1;
        m = m ^ (m >> 15);
        m = m * 32'h85EBCA77;
        m = m ^ (m >> 13);
        return {8'h5A, {215{1'b0}}, 1'b1, m};
    endfunction

    always @(posedge clk) begin
        if (stub_kill) stub_cnt = 0;
        if (sha_start === 1'b1) begin
            stub_n   = swap32(sha_block[31:0]);
            stub_cnt = lat;
            starts++;
            if (!hold_hi) begin
                #1 sha_done = 1'b0;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                #1;
                sha_hash = hash_fn(stub_n);
                sha_done = 1'b1;
            end
        end else if (drop_req != drop_ack) begin
            drop_ack = drop_req;
            stub_cnt = 1;
            #1 sha_done = 1'b0;
        end
    end

    // ---------------- reference search model ----------------
    function automatic int tz(input logic [255:0] h);
        for (int i = 0; i < 256; i++) if (h[i]) return i;
        return 256;
    endfunction

    task automatic model(input logic [31:0] n0, input int zb, output bit f, output bit ex,
                         output logic [31:0] fn, output int att);
        longint unsigned n;
        n = 64'(n0); f = 0; ex = 0; fn = '0; att = 0;
        while (att < 1000) begin
            att++;
            if (tz(hash_fn(n[31:0])) >= zb) begin
                f = 1; fn = n[31:0];
                break;
            end
            if (n + 64'(STRIDE) > 64'hFFFF_FFFF) begin
                ex = 1;
                break;
            end
            n = n + 64'(STRIDE);
        end
    endtask

    // ---------------- helpers (all start and end on a negedge) ----------------
    logic [7:0] hdr [80];

    task automatic set_hdr(input logic [31:0] n);
        for (int k = 0; k < 76; k++) hdr[k] = 8'($urandom);
        hdr[76] = n[7:0];
        hdr[77] = n[15:8];
        hdr[78] = n[23:16];
        hdr[79] = n[31:24];
    endtask

    function automatic logic [639:0] exp_blk();
        logic [639:0] b;
        b = '0;
        for (int k = 0; k < 80; k++) b[639-8*k -: 8] = hdr[k];
        return b;
    endfunction

    task automatic load_hdr();
        for (int k = 0; k < 80; k++) begin
            load_valid = 1'b1;
            load_data  = hdr[k];
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic run_wait(input int limit, output int cyc);
        run = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            run = 1'b0;
        end while (!(found || exhausted) && cyc < limit);
    endtask

    typedef struct {
        string       name;
        logic [31:0] n;
        logic [7:0]  zb;
        bit          ef;
        bit          ex;
        logic [31:0] efn;
        int          st;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base, att;
        bit mf, mex;
        logic [31:0] mfn, n;
        int zb;

        tbl[0] = '{"genesis_z40",   GEN_N,         8'd40, 1'b1, 1'b0, GEN_N,         1};
        tbl[1] = '{"genesis_walk",  GEN_N - 32'd6, 8'd40, 1'b1, 1'b0, GEN_N,         3};
        tbl[2] = '{"exhaust_over",  32'hFFFFFFF8,  8'd8,  1'b0, 1'b1, 32'h0,         3};
        tbl[3] = '{"exhaust_exact", 32'hFFFFFFF9,  8'd8,  1'b0, 1'b1, 32'h0,         3};
        tbl[4] = '{"zbits0",        32'h12345678,  8'd0,  1'b1, 1'b0, 32'h12345678,  1};
        tbl[5] = '{"top_hit",       32'hFFFFFFFF,  8'd0,  1'b1, 1'b0, 32'hFFFFFFFF,  1};
        tbl[6] = '{"top_miss",      32'hFFFFFFFF,  8'd1,  1'b0, 1'b1, 32'h0,         1};

        // reset state
        @(negedge clk);
        chk1("rst_sha_start", sha_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_found", found, 1'b0);
        chk1("rst_exhausted", exhausted, 1'b0);
        chk32("rst_found_nonce", found_nonce, 32'h0);
        chkb("rst_sha_block", sha_block, '0);
        chk1("rst_load_ready", load_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // run with nothing loaded is ignored
        base = starts;
        pulse_run();
        repeat (4) @(negedge clk);
        chk1("unloaded_run_busy", busy, 1'b0);
        chk1("unloaded_run_ready", load_ready, 1'b1);
        chk32("unloaded_run_starts", 32'(starts - base), 32'd0);

        // directed vector table
        lat = 4;
        fixed_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_abort();
            zbits = tbl[i].zb;
            set_hdr(tbl[i].n);
            load_hdr();
            chkb({tbl[i].name, "_block"}, sha_block, exp_blk());
            base = starts;
            run_wait(tbl[i].st * (lat + 3) + 20, cyc);
            chk1({tbl[i].name, "_found"}, found, tbl[i].ef);
            chk1({tbl[i].name, "_exhausted"}, exhausted, tbl[i].ex);
            if (tbl[i].ef) chk32({tbl[i].name, "_nonce"}, found_nonce, tbl[i].efn);
            chk32({tbl[i].name, "_starts"}, 32'(starts - base), 32'(tbl[i].st));
            chk32({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].st * (lat + 3) + 1));
            chk1({tbl[i].name, "_busy"}, busy, 1'b0);
`ifdef HASH_COUNTER_EN
            chk32({tbl[i].name, "_hash_count"}, hash_count, 32'(tbl[i].st));
`endif
        end

        // run in EXHAUSTED with no stride room is ignored
        base = starts;
        pulse_run();
        repeat (5) @(negedge clk);
        chk1("exh_run_exhausted", exhausted, 1'b1);
        chk32("exh_run_starts", 32'(starts - base), 32'd0);

        // run in FOUND advances by the stride
        do_abort();
        zbits = 8'd0;
        set_hdr(32'h00000100);
        load_hdr();
        run_wait(30, cyc);
        chk32("found_first_nonce", found_nonce, 32'h00000100);
        base = starts;
        run_wait(30, cyc);
        chk1("found_rerun_found", found, 1'b1);
        chk32("found_rerun_nonce", found_nonce, 32'h00000100 + STRIDE);
        chk32("found_rerun_starts", 32'(starts - base), 32'd1);
        chk32("found_rerun_block", sha_block[31:0], swap32(32'h00000100 + STRIDE));

        // abort wins over run in the same cycle
        base = starts;
        abort = 1'b1;
        run = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run = 1'b0;
        chk1("abort_prio_found", found, 1'b0);
        chk1("abort_prio_ready", load_ready, 1'b1);
        repeat (5) @(negedge clk);
        chk32("abort_prio_starts", 32'(starts - base), 32'd0);

        // genesis with zbits=41 misses and moves on
        zbits = 8'd41;
        set_hdr(GEN_N);
        load_hdr();
        base = starts;
        pulse_run();
        cyc = 0;
        while ((starts - base) < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk1("z41_found", found, 1'b0);
        chk32("z41_starts", 32'(starts - base), 32'd2);
        chk32("z41_next_nonce", swap32(sha_block[31:0]), GEN_N + STRIDE);
        do_abort();
        repeat (lat + 5) @(negedge clk);

        // sha_done held high: only a fresh rising edge completes WAIT
        hold_hi = 1'b1;
        zbits = 8'd8;
        base = starts;
        pulse_run();
        repeat (25) @(negedge clk);
        chk1("hold_busy", busy, 1'b1);
        chk1("hold_found", found, 1'b0);
        chk32("hold_starts", 32'(starts - base), 32'd1);
        drop_req = ~drop_req;
        repeat (25) @(negedge clk);
        chk32("hold_edge_starts", 32'(starts - base), 32'd2);
        chk1("hold_edge_busy", busy, 1'b1);
        chk32("hold_edge_nonce", swap32(sha_block[31:0]), GEN_N + 2 * STRIDE);
        do_abort();
        hold_hi = 1'b0;

        // abort in WAIT; stray load bytes outside IDLE are ignored
        lat = 12;
        zbits = 8'd40;
        set_hdr(GEN_N);
        load_hdr();
        base = starts;
        pulse_run();
        repeat (3) @(negedge clk);
        chk1("wait_busy", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data = 8'hEE;
            @(negedge clk);
        end
        load_valid = 1'b0;
        stub_kill = 1'b1;
        do_abort();
        chk1("abort_wait_ready", load_ready, 1'b1);
        chk1("abort_wait_busy", busy, 1'b0);
        chk1("abort_wait_start", sha_start, 1'b0);
        chkb("abort_wait_block", sha_block, exp_blk());
        repeat (lat + 4) @(negedge clk);
        stub_kill = 1'b0;
        chk32("abort_wait_starts", 32'(starts - base), 32'd1);
        chk1("abort_wait_found", found, 1'b0);
        run_wait(lat + 30, cyc);
        chk1("abort_rerun_found", found, 1'b1);
        chk32("abort_rerun_nonce", found_nonce, GEN_N);
        do_abort();
        set_hdr(32'hA5A50F0F);
        load_hdr();
        chkb("post_ignore_load_block", sha_block, exp_blk());

        // reset mid-WAIT
        lat = 8;
        zbits = 8'd40;
        base = starts;
        pulse_run();
        repeat (3) @(negedge clk);
        chk1("rstwait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        chk1("rstwait_busy0", busy, 1'b0);
        chk1("rstwait_start0", sha_start, 1'b0);
        chk1("rstwait_found0", found, 1'b0);
        chk1("rstwait_exh0", exhausted, 1'b0);
        chk32("rstwait_nonce0", found_nonce, 32'h0);
        chkb("rstwait_block0", sha_block, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (lat + 5) @(negedge clk);
        chk1("rstwait_late_done_busy", busy, 1'b0);
        chk1("rstwait_late_done_found", found, 1'b0);
        chk1("rstwait_late_done_ready", load_ready, 1'b1);
        pulse_run();
        repeat (5) @(negedge clk);
        chk1("rstwait_unloaded_busy", busy, 1'b0);
        chk32("rstwait_starts", 32'(starts - base), 32'd1);

        // randomized search against the model
        fixed_mode = 1'b0;
        for (int it = 0; it < 20; it++) begin
            lat = int'($urandom_range(1, 6));
            zb = int'($urandom_range(0, 4));
            n = $urandom;
            if ($urandom_range(0, 3) == 0) n = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            model(n, zb, mf, mex, mfn, att);
            if (att > 200) begin
                zb = 0;
                model(n, zb, mf, mex, mfn, att);
            end
            zbits = 8'(zb);
            do_abort();
            set_hdr(n);
            load_hdr();
            base = starts;
            run_wait(att * (lat + 3) + 20, cyc);
            chk1("rand_found", found, mf);
            chk1("rand_exhausted", exhausted, mex);
            if (mf) chk32("rand_nonce", found_nonce, mfn);
            chk32("rand_starts", 32'(starts - base), 32'(att));
            chk32("rand_cycles", 32'(cyc), 32'(att * (lat + 3) + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
